// File: rtl/ysyx_24110006_csr_file.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_csr_file
// Machine-mode CSR file for a single-hart RISC-V core: CSR read/modify/write,
// ECALL / MRET / timer-interrupt trap sequencing and 64-bit mcycle/minstret.
//
// Ports
//   i_clock, i_reset          : clock, synchronous active-high reset
//   i_valid                   : current op is live (counters run regardless)
//   i_op                      : 0 NONE, 1 CSRRW, 2 CSRRS, 3 CSRRC, 4 ECALL, 5 MRET
//   i_csr, i_wdata            : CSR address and write operand
//   i_pc, i_mcause            : pc of the current instruction, ECALL cause
//   i_retire                  : one instruction retired this cycle
//   i_irq                     : level timer-interrupt request (mip.MTIP)
//   o_rdata                   : combinational pre-write value of i_csr
//   o_upc, o_redirect         : redirect target and its valid
//   o_illegal, o_irq_take     : CSR access fault, interrupt accepted
// ---------------------------------------------------------------------------
module ysyx_24110006_csr_file #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] MVENDORID = 32'h79737978,
  parameter logic [31:0] MARCHID   = 32'h016FE3B8
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_valid,
  input  logic [2:0]      i_op,
  input  logic [11:0]     i_csr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_mcause,
  input  logic            i_retire,
  input  logic            i_irq,
  output logic [XLEN-1:0] o_rdata,
  output logic [XLEN-1:0] o_upc,
  output logic            o_redirect,
  output logic            o_illegal,
  output logic            o_irq_take
);

  localparam logic [2:0] OP_CSRRW = 3'd1;
  localparam logic [2:0] OP_CSRRS = 3'd2;
  localparam logic [2:0] OP_CSRRC = 3'd3;
  localparam logic [2:0] OP_ECALL = 3'd4;
  localparam logic [2:0] OP_MRET  = 3'd5;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  // Machine timer interrupt cause: interrupt flag in the MSB, code 7.
  localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, (XLEN-1)'(7)};

  // Architectural state; mstatus keeps only its two writable bits.
  logic            st_mie, st_mpie, mtie;
  logic [XLEN-1:0] mtvec, mepc, mcause;
  logic [63:0]     mcycle, minstret;

  logic [XLEN-1:0] mtvec_rd, mepc_rd, old_val, new_val;
  logic [63:0]     wval64, cyc_next, ret_next;
  logic            implemented, read_only, is_write, csr_op, wr_en;
  logic            live, irq_take, ecall_go, mret_go;

  // Low address bits are stored but always read back as zero.
  assign mtvec_rd = mtvec & ~XLEN'(3);
  assign mepc_rd  = mepc  & ~XLEN'(1);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case statements can leave it unassigned (no latch).
  always_comb begin
    old_val     = '0;
    implemented = 1'b1;
    read_only   = 1'b0;
    case (i_csr)
      CSR_MSTATUS:   old_val = XLEN'(32'h1800) | (XLEN'(st_mpie) << 7) | (XLEN'(st_mie) << 3);
      CSR_MIE:       old_val = XLEN'(mtie) << 7;
      CSR_MTVEC:     old_val = mtvec_rd;
      CSR_MEPC:      old_val = mepc_rd;
      CSR_MCAUSE:    old_val = mcause;
      CSR_MIP: begin
        old_val   = XLEN'(i_irq) << 7;
        read_only = 1'b1;
      end
      CSR_MCYCLE:    old_val = XLEN'(mcycle);
      CSR_MINSTRET:  old_val = XLEN'(minstret);
      CSR_MCYCLEH: begin
        if (XLEN == 32) old_val = XLEN'(mcycle[63:32]);
        else            implemented = 1'b0;
      end
      CSR_MINSTRETH: begin
        if (XLEN == 32) old_val = XLEN'(minstret[63:32]);
        else            implemented = 1'b0;
      end
      CSR_MVENDORID: begin
        old_val   = XLEN'(MVENDORID);
        read_only = 1'b1;
      end
      CSR_MARCHID: begin
        old_val   = XLEN'(MARCHID);
        read_only = 1'b1;
      end
      default:       implemented = 1'b0;
    endcase
  end

  always_comb begin
    case (i_op)
      OP_CSRRS: new_val = old_val | i_wdata;
      OP_CSRRC: new_val = old_val & ~i_wdata;
      default:  new_val = i_wdata;
    endcase
  end

  // Reset overrides everything; an accepted interrupt suppresses the op.
  assign irq_take = i_valid & ~i_reset & i_irq & st_mie & mtie;
  assign live     = i_valid & ~i_reset & ~irq_take;
  assign ecall_go = live && (i_op == OP_ECALL);
  assign mret_go  = live && (i_op == OP_MRET);
  assign csr_op   = live && (i_op == OP_CSRRW || i_op == OP_CSRRS || i_op == OP_CSRRC);
  // Set/clear with a zero mask is a pure read and must not fault on read-only CSRs.
  assign is_write = (i_op == OP_CSRRW) || (i_wdata != '0);

  assign o_illegal  = csr_op & (~implemented | (is_write & read_only));
  assign wr_en      = csr_op & is_write & ~o_illegal;
  assign o_irq_take = irq_take;
  assign o_redirect = irq_take | ecall_go | mret_go;
  assign o_upc      = (irq_take | ecall_go) ? mtvec_rd : (mret_go ? mepc_rd : '0);
  assign o_rdata    = old_val;

  // Counter next values: a software write to either half replaces the
  // increment for that counter in that cycle.
  assign wval64 = 64'(new_val);

  always_comb begin
    cyc_next = mcycle + 64'd1;
    ret_next = minstret + (i_retire ? 64'd1 : 64'd0);
    if (wr_en) begin
      case (i_csr)
        CSR_MCYCLE:    cyc_next = (XLEN == 32) ? {mcycle[63:32], wval64[31:0]} : wval64;
        CSR_MCYCLEH:   cyc_next = {wval64[31:0], mcycle[31:0]};
        CSR_MINSTRET:  ret_next = (XLEN == 32) ? {minstret[63:32], wval64[31:0]} : wval64;
        CSR_MINSTRETH: ret_next = {wval64[31:0], minstret[31:0]};
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      mtie     <= 1'b0;
      mtvec    <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= cyc_next;
      minstret <= ret_next;
      if (irq_take || ecall_go) begin
        mepc    <= i_pc;
        mcause  <= irq_take ? IRQ_CAUSE : i_mcause;
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (mret_go) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (wr_en) begin
        case (i_csr)
          CSR_MSTATUS: begin
            st_mie  <= new_val[3];
            st_mpie <= new_val[7];
          end
          CSR_MIE:    mtie   <= new_val[7];
          CSR_MTVEC:  mtvec  <= new_val;
          CSR_MEPC:   mepc   <= new_val;
          CSR_MCAUSE: mcause <= new_val;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24110006_csr_file.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24110006_csr_file
// Directed self-checking bench for the CSR file (XLEN = 32). Inputs change
// 1 time unit after a rising edge; combinational outputs are sampled 1 unit
// later, well before the next edge.
// ---------------------------------------------------------------------------
module tb_ysyx_24110006_csr_file;

  localparam int XLEN = 32;

  logic            i_clock = 1'b0;
  logic            i_reset;
  logic            i_valid;
  logic [2:0]      i_op;
  logic [11:0]     i_csr;
  logic [XLEN-1:0] i_wdata, i_pc, i_mcause;
  logic            i_retire, i_irq;
  logic [XLEN-1:0] o_rdata, o_upc;
  logic            o_redirect, o_illegal, o_irq_take;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_24110006_csr_file #(.XLEN(XLEN)) dut (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_valid   (i_valid),
    .i_op      (i_op),
    .i_csr     (i_csr),
    .i_wdata   (i_wdata),
    .i_pc      (i_pc),
    .i_mcause  (i_mcause),
    .i_retire  (i_retire),
    .i_irq     (i_irq),
    .o_rdata   (o_rdata),
    .o_upc     (o_upc),
    .o_redirect(o_redirect),
    .o_illegal (o_illegal),
    .o_irq_take(o_irq_take)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present an op and let the combinational outputs settle.
  task automatic drive(input logic [2:0] op, input logic [11:0] csr, input logic [31:0] wdata);
    i_valid = 1'b1;
    i_op    = op;
    i_csr   = csr;
    i_wdata = wdata;
    #1;
  endtask

  // Clock edge, then return to idle inputs.
  task automatic tick();
    @(posedge i_clock);
    #1;
    i_valid = 1'b0;
    i_op    = 3'd0;
    i_wdata = '0;
  endtask

  // Passive read: no live op, so no state changes.
  task automatic rd(input logic [11:0] csr, output logic [31:0] val);
    i_valid = 1'b0;
    i_op    = 3'd0;
    i_csr   = csr;
    #1;
    val = o_rdata;
  endtask

  logic [31:0] v;

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_op = 3'd0; i_csr = '0; i_wdata = '0;
    i_pc = '0; i_mcause = '0; i_retire = 1'b0; i_irq = 1'b0;
    tick();

    // Reset held during a live ECALL: no redirect, state stays at reset values.
    i_pc = 32'h0000_1234; i_mcause = 32'd11;
    drive(3'd4, 12'h000, 32'h0);
    check("rst_redirect", 64'(o_redirect), 64'h0);
    tick();
    i_reset = 1'b0;
    rd(12'h341, v); check("rst_mepc", 64'(v), 64'h0);
    rd(12'h300, v); check("rst_mstatus", 64'(v), 64'h1800);
    rd(12'h342, v); check("rst_mcause", 64'(v), 64'h0);
    rd(12'hB00, v); check("rst_mcycle", 64'(v), 64'h0);
    rd(12'hB02, v); check("rst_minstret", 64'(v), 64'h0);

    // Counter starts on the first edge after reset release.
    tick(); tick(); tick();
    rd(12'hB00, v); check("mcycle_run", 64'(v), 64'd3);

    // mtvec low bits read as zero; o_rdata shows the pre-write value.
    drive(3'd1, 12'h305, 32'h8000_0103);
    check("mtvec_old", 64'(o_rdata), 64'h0);
    check("mtvec_legal", 64'(o_illegal), 64'h0);
    tick();
    rd(12'h305, v); check("mtvec_rd", 64'(v), 64'h8000_0100);

    // CSRRS mstatus.MIE.
    drive(3'd2, 12'h300, 32'h8);
    check("csrrs_old", 64'(o_rdata), 64'h1800);
    tick();
    rd(12'h300, v); check("mstatus_mie", 64'(v), 64'h1808);

    // ECALL then MRET.
    i_pc = 32'h8000_0010; i_mcause = 32'd11;
    drive(3'd4, 12'h000, 32'h0);
    check("ecall_redirect", 64'(o_redirect), 64'h1);
    check("ecall_upc", 64'(o_upc), 64'h8000_0100);
    tick();
    rd(12'h341, v); check("ecall_mepc", 64'(v), 64'h8000_0010);
    rd(12'h342, v); check("ecall_mcause", 64'(v), 64'd11);
    rd(12'h300, v); check("ecall_mstatus", 64'(v), 64'h1880);
    drive(3'd5, 12'h000, 32'h0);
    check("mret_upc", 64'(o_upc), 64'h8000_0010);
    check("mret_redirect", 64'(o_redirect), 64'h1);
    tick();
    rd(12'h300, v); check("mret_mstatus", 64'(v), 64'h1888);
    check("idle_upc", 64'(o_upc), 64'h0);

    // mip follows i_irq and is read-only.
    i_irq = 1'b1;
    rd(12'h344, v); check("mip_mtip", 64'(v), 64'h80);
    i_irq = 1'b0;
    drive(3'd1, 12'h344, 32'h80);
    check("mip_write_illegal", 64'(o_illegal), 64'h1);
    tick();

    // Enable MTIE (only bit 7 sticks), then interrupt beats a CSRRW to mepc.
    drive(3'd1, 12'h304, 32'hFFFF_FFFF);
    tick();
    rd(12'h304, v); check("mie_mtie", 64'(v), 64'h80);
    i_irq = 1'b1; i_pc = 32'h8000_0200;
    drive(3'd1, 12'h341, 32'hDEAD_0000);
    check("irq_take", 64'(o_irq_take), 64'h1);
    check("irq_upc", 64'(o_upc), 64'h8000_0100);
    check("irq_no_illegal", 64'(o_illegal), 64'h0);
    tick();
    i_irq = 1'b0;
    rd(12'h342, v); check("irq_mcause", 64'(v), 64'h8000_0007);
    rd(12'h341, v); check("irq_mepc", 64'(v), 64'h8000_0200);
    rd(12'h300, v); check("irq_mstatus", 64'(v), 64'h1880);

    // i_valid low: nothing live, no redirect.
    i_pc = 32'h0000_0044;
    i_valid = 1'b0; i_op = 3'd4; #1;
    check("novalid_redirect", 64'(o_redirect), 64'h0);
    tick();
    rd(12'h341, v); check("novalid_mepc", 64'(v), 64'h8000_0200);

    // Read-only and unimplemented addresses.
    drive(3'd1, 12'hF11, 32'h1234_5678);
    check("f11_illegal", 64'(o_illegal), 64'h1);
    tick();
    rd(12'hF11, v); check("mvendorid", 64'(v), 64'h7973_7978);
    rd(12'hF12, v); check("marchid", 64'(v), 64'h016F_E3B8);
    drive(3'd2, 12'h7C0, 32'h1);
    check("7c0_illegal", 64'(o_illegal), 64'h1);
    check("7c0_rdata", 64'(o_rdata), 64'h0);
    tick();

    // CSRRC clears MPIE.
    drive(3'd3, 12'h300, 32'h80);
    check("csrrc_old", 64'(o_rdata), 64'h1880);
    tick();
    rd(12'h300, v); check("csrrc_mstatus", 64'(v), 64'h1800);

    // mcycle carry into mcycleh; writes suppress the increment.
    drive(3'd1, 12'hB80, 32'h0);
    tick();
    drive(3'd1, 12'hB00, 32'hFFFF_FFFF);
    tick();
    rd(12'hB00, v); check("mcycle_written", 64'(v), 64'hFFFF_FFFF);
    tick();
    rd(12'hB00, v); check("mcycle_wrap", 64'(v), 64'h0);
    rd(12'hB80, v); check("mcycleh_carry", 64'(v), 64'h1);

    // minstret: write wins over a simultaneous retire, then counts retires.
    i_retire = 1'b1;
    drive(3'd1, 12'hB02, 32'd5);
    tick();
    tick();
    tick();
    i_retire = 1'b0;
    rd(12'hB02, v); check("minstret", 64'(v), 64'd7);
    rd(12'hB82, v); check("minstreth", 64'(v), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
